rom_stream_tx: RTL and testbench
================================

# rom_stream_tx

Transmitter side of the ROM download byte stream consumed by `rom_loader`. It is used in simulation benches and in the bridge-to-core path to serialise ROM contents. It emits one board-config byte, then for each entry of a fixed region table a region-index byte, a 24-bit big-endian size, and `size` data bytes pulled from a byte-stream source. It paces `ioctl_wr` pulses so that a rising-edge-capturing receiver sees every byte and its `ioctl_wait` back-pressure is honoured.

## Interface
Parameters:
- `WR_GAP`, 2: minimum number of low cycles on `ioctl_wr` after each pulse, range 1..15.
- `NUM_REGIONS`, `TX_REGION_COUNT`: number of table entries sent, taken from the package, range 1..16.

Ports:
- `sys_clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle request to begin a download. Sampled only in IDLE.
- `board_cfg` in 8: first byte sent. Latched on the cycle `start` is accepted.
- `src_valid` in 1: a source data byte is available.
- `src_data` in 8: source data byte.
- `src_ready` out 1: pop strobe, combinational. A byte is consumed when `src_valid & src_ready`.
- `ioctl_downl` out 1: download in progress.
- `ioctl_wr` out 1: byte strobe, high for exactly one cycle per byte.
- `ioctl_data` out 8: byte value. Stable from the pulse cycle through the end of its gap.
- `ioctl_wait` in 1: receiver back-pressure.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the stream is complete.

## Operation
- States: IDLE, OPEN, CFG, IDX, S0, S1, S2, DATA, CLOSE.
- In every state except IDLE and OPEN, each byte goes through two phases:
  - PULSE: `ioctl_wr`=1 for one cycle.
  - GAP: `ioctl_wr`=0 until both of these hold: at least `WR_GAP` gap cycles have elapsed, and `ioctl_wait` is sampled 0 on the current cycle.
- A state's next byte can launch only after its GAP condition is met. The next state's byte launches on the cycle after that.
- IDLE: on `start`, latch `board_cfg`, clear the region index, go to OPEN.
- OPEN: drive `ioctl_downl`=1 for one cycle with no pulse, then go to CFG.
- CFG: send `board_cfg`, then go to IDX.
- IDX: send `TX_REGIONS[r].idx`.
- S0, S1, S2: send `size[23:16]`, `size[15:8]`, `size[7:0]`.
- After S2:
  - If size == 0, the region has no data. Advance r, then go to IDX if r < NUM_REGIONS, otherwise CLOSE.
  - Otherwise load the 24-bit down-counter with size and go to DATA.
- DATA:
  - `src_ready`=1 only when the gap is satisfied, no pulse is pending, and `src_valid`=1.
  - On a pop, register `src_data` into `ioctl_data`. PULSE follows on the next cycle.
  - Each pop decrements the counter.
  - After the GAP of the byte that took the counter to 0: advance r, then go to IDX or CLOSE.
  - With `src_valid` low, wait indefinitely. No timeout.
- CLOSE: drop `ioctl_downl`, pulse `done` for one cycle, go to IDLE.
- `start` in any non-IDLE state is ignored.
- An active `reset` at any time forces IDLE and all outputs low. A partially sent stream is abandoned. The receiver resynchronises through `ioctl_downl`=0.
- The counter is 24 bits wide. The maximum size is 2^24-1, and no wrap-around is possible.

## Timing
- Reset value of every output is 0, including `ioctl_data`=8'h00.
- `start` is accepted at cycle 0. `ioctl_downl`=1 and `busy`=1 from cycle 1. The first `ioctl_wr` pulse (`board_cfg`) is at cycle 2.
- Unthrottled throughput is one byte per `WR_GAP`+1 cycles.
- `ioctl_wait` is ignored during PULSE and the first gap cycle. This covers the receiver's registered wait assertion.
- With a continuously valid source, the pop happens in the last gap cycle of the previous byte, so there are no bubbles.
- `ioctl_downl` falls on the cycle after the last gap completes. `done` is high on that same cycle. `busy` falls one cycle later.

## Structure
- `xain_pkg` holds:
  - `tx_region_t` struct: `idx` [7:0], `size` [23:0].
  - `TX_REGION_COUNT`.
  - `TX_REGIONS` constant array, one entry per `LOAD_REGIONS` slot.
- State enum `tx_stage_t` is declared locally.
- Sub-module `ioctl_byte_pacer` owns the PULSE/GAP timer, the `ioctl_wait` sampling and the `ioctl_data` register. It exposes `launch`/`ready` to the main FSM.

## Test plan
- Nominal run:
  - Setup: `board_cfg`=8'h5A, table {idx 0 size 4, idx 2 size 0}, `WR_GAP`=2, source always valid with bytes 11 22 33 44.
  - Expected stream: 5A 00 00 00 04 11 22 33 44 02 00 00 00.
  - Expected pacing: pulses 3 cycles apart, `done` once, `ioctl_downl` low afterwards.
- Back-pressure: hold `ioctl_wait`=1 for 10 cycles after the S1 pulse. The S2 pulse must be delayed until wait is seen low. No byte may be lost or duplicated.
- Source starvation: `src_valid` low for 20 cycles mid-DATA. `ioctl_wr` must stay low, `src_ready` must stay 0, and the stream resumes with the correct next byte.
- Loader loopback: connect to `rom_loader` with an SDRAM stub that acks after 5 cycles, 256-byte region. The stub memory must contain bytes 0..255 at the region base.
- Reset mid-DATA: assert `reset` at byte 100 of 256. All outputs must be 0 immediately. A fresh `start` must then produce a full, correct stream.
- Ignored start: pulse `start` while `busy`. The stream must be unaffected and exactly one `done` must be produced.

Source files
------------

// File: rtl/xain_pkg.sv
// ROM region table and shared types for the
// ROM download byte stream transmitter.
package xain_pkg;

  typedef struct packed {
    logic [7:0]  idx;
    logic [23:0] size;
  } tx_region_t;

  localparam int TX_REGION_COUNT = 3;

  localparam tx_region_t TX_REGIONS [TX_REGION_COUNT] = '{
    '{idx: 8'h00, size: 24'd4},
    '{idx: 8'h02, size: 24'd0},
    '{idx: 8'h05, size: 24'd256}
  };

  // Indices past the table read as an empty entry.
  function automatic tx_region_t tx_region(
    input logic [4:0] i
  );
    tx_region = '0;
    for (int k = 0; k < TX_REGION_COUNT; k++)
      if (i == 5'(k)) tx_region = TX_REGIONS[k];
  endfunction

  function automatic logic [7:0] tx_idx(
    input logic [4:0] i
  );
    tx_idx = 8'h00;
    for (int k = 0; k < TX_REGION_COUNT; k++)
      if (i == 5'(k)) tx_idx = TX_REGIONS[k].idx;
  endfunction

endpackage

// File: rtl/rom_stream_tx_pacer.sv
// Byte pacer: one-cycle ioctl_wr pulse, then a
// gap of at least WR_GAP cycles honouring ioctl_wait.
module ioctl_byte_pacer #(
  parameter int WR_GAP = 2
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       launch,
  input  logic [7:0] launch_data,
  input  logic       ioctl_wait,
  output logic       ready,
  output logic       ioctl_wr,
  output logic [7:0] ioctl_data
);

  logic [3:0] gap_cnt;

  // gap_cnt is 0 on the pulse, 1 on the first gap
  // cycle, and saturates so an idle pacer is ready.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ioctl_wr   <= 1'b0;
      ioctl_data <= 8'h00;
      gap_cnt    <= 4'hF;
    end else if (launch) begin
      ioctl_wr   <= 1'b1;
      ioctl_data <= launch_data;
      gap_cnt    <= 4'h0;
    end else begin
      ioctl_wr <= 1'b0;
      if (gap_cnt != 4'hF)
        gap_cnt <= gap_cnt + 4'h1;
    end
  end

  // The receiver registers its wait, so the first
  // gap cycle cannot reflect the byte just sent.
  always_comb begin
    ready = ~ioctl_wr
          & (gap_cnt >= 4'(WR_GAP))
          & (~ioctl_wait | (gap_cnt == 4'h1));
  end

endmodule

// File: rtl/rom_stream_tx.sv
// ROM download stream transmitter: board config,
// then per region an index, 24-bit size and data.
module rom_stream_tx
  import xain_pkg::*;
#(
  parameter int WR_GAP      = 2,
  parameter int NUM_REGIONS = TX_REGION_COUNT
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] board_cfg,
  input  logic       src_valid,
  input  logic [7:0] src_data,
  output logic       src_ready,
  output logic       ioctl_downl,
  output logic       ioctl_wr,
  output logic [7:0] ioctl_data,
  input  logic       ioctl_wait,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OPEN,
    ST_CFG,
    ST_IDX,
    ST_S0,
    ST_S1,
    ST_S2,
    ST_DATA,
    ST_CLOSE
  } tx_stage_t;

  tx_stage_t   state, state_nx;
  logic [7:0]  cfg_q, cfg_nx;
  logic [4:0]  rgn_q, rgn_nx;
  logic [23:0] cnt_q, cnt_nx;

  logic        launch;
  logic [7:0]  launch_data;
  logic        pace_ready;

  tx_region_t  cur;
  logic [4:0]  rgn_inc;
  logic [7:0]  nxt_idx;
  logic        last_rgn;

  assign cur      = tx_region(rgn_q);
  assign rgn_inc  = rgn_q + 5'd1;
  assign nxt_idx  = tx_idx(rgn_inc);
  assign last_rgn = rgn_inc >= 5'(NUM_REGIONS);

  ioctl_byte_pacer #(.WR_GAP(WR_GAP)) u_pacer (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .launch      (launch),
    .launch_data (launch_data),
    .ioctl_wait  (ioctl_wait),
    .ready       (pace_ready),
    .ioctl_wr    (ioctl_wr),
    .ioctl_data  (ioctl_data)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cfg_q <= 8'h00;
      rgn_q <= 5'd0;
      cnt_q <= 24'd0;
    end else begin
      state <= state_nx;
      cfg_q <= cfg_nx;
      rgn_q <= rgn_nx;
      cnt_q <= cnt_nx;
    end
  end

  // The state names the byte in flight; the next
  // byte launches on the cycle its gap is met.
  always_comb begin
    state_nx    = state;
    cfg_nx      = cfg_q;
    rgn_nx      = rgn_q;
    cnt_nx      = cnt_q;
    launch      = 1'b0;
    launch_data = 8'h00;
    src_ready   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_OPEN;
          cfg_nx   = board_cfg;
          rgn_nx   = 5'd0;
        end
      end
      ST_OPEN: begin
        launch      = 1'b1;
        launch_data = cfg_q;
        state_nx    = ST_CFG;
      end
      ST_CFG: begin
        if (pace_ready) begin
          launch      = 1'b1;
          launch_data = cur.idx;
          state_nx    = ST_IDX;
        end
      end
      ST_IDX: begin
        if (pace_ready) begin
          launch      = 1'b1;
          launch_data = cur.size[23:16];
          state_nx    = ST_S0;
        end
      end
      ST_S0: begin
        if (pace_ready) begin
          launch      = 1'b1;
          launch_data = cur.size[15:8];
          state_nx    = ST_S1;
        end
      end
      ST_S1: begin
        if (pace_ready) begin
          launch      = 1'b1;
          launch_data = cur.size[7:0];
          state_nx    = ST_S2;
        end
      end
      ST_S2: begin
        if (pace_ready && cur.size == 24'd0) begin
          rgn_nx = rgn_inc;
          if (last_rgn) begin
            state_nx = ST_CLOSE;
          end else begin
            launch      = 1'b1;
            launch_data = nxt_idx;
            state_nx    = ST_IDX;
          end
        end else if (pace_ready) begin
          state_nx = ST_DATA;
          cnt_nx   = cur.size;
          if (src_valid) begin
            src_ready   = 1'b1;
            launch      = 1'b1;
            launch_data = src_data;
            cnt_nx      = cur.size - 24'd1;
          end
        end
      end
      ST_DATA: begin
        if (pace_ready && cnt_q == 24'd0) begin
          rgn_nx = rgn_inc;
          if (last_rgn) begin
            state_nx = ST_CLOSE;
          end else begin
            launch      = 1'b1;
            launch_data = nxt_idx;
            state_nx    = ST_IDX;
          end
        end else if (pace_ready && src_valid) begin
          src_ready   = 1'b1;
          launch      = 1'b1;
          launch_data = src_data;
          cnt_nx      = cnt_q - 24'd1;
        end
      end
      ST_CLOSE: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ioctl_downl = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (1'b1)
      state == ST_IDLE:  busy = 1'b0;
      state == ST_CLOSE: done = 1'b1;
      default:           ioctl_downl = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_rom_stream_tx.sv
// Scoreboard bench for rom_stream_tx: expected bytes
// come from the region table and the source contents.
module tb_rom_stream_tx;
  import xain_pkg::*;

  localparam int WR_GAP = 2;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] board_cfg;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic       ioctl_downl;
  logic       ioctl_wr;
  logic [7:0] ioctl_data;
  logic       ioctl_wait;
  logic       busy;
  logic       done;

  rom_stream_tx #(.WR_GAP(WR_GAP)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .start       (start),
    .board_cfg   (board_cfg),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .ioctl_downl (ioctl_downl),
    .ioctl_wr    (ioctl_wr),
    .ioctl_data  (ioctl_data),
    .ioctl_wait  (ioctl_wait),
    .busy        (busy),
    .done        (done)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] src_mem [512];
  logic [7:0] exp_q [$];

  int  src_pos, drv_pulses, bp_at, starve_at;
  int  bp_left = 0, starve_left = 0;
  bit  rnd_valid, rnd_wait, strict, starving;
  bit  popped;
  int  done_n, pulse_n, cyc, last_cyc, bp_gap;
  bit  starve_bad, rdy_bad, moved, wait_prev;
  logic [7:0] last_data;

  task automatic check_eq(input string name,
                          input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  name, act, exp);
  endtask

  // Reference stream: cfg, then per table entry
  // idx, big-endian size, and size source bytes.
  task automatic build_exp(input logic [7:0] cfg);
    int pos;
    tx_region_t rg;
    pos = 0;
    exp_q.delete();
    exp_q.push_back(cfg);
    for (int r = 0; r < TX_REGION_COUNT; r++) begin
      rg = TX_REGIONS[r];
      exp_q.push_back(rg.idx);
      exp_q.push_back(8'((rg.size / 65536) % 256));
      exp_q.push_back(8'((rg.size / 256) % 256));
      exp_q.push_back(8'(rg.size % 256));
      for (int b = 0; b < int'(rg.size); b++) begin
        exp_q.push_back(src_mem[pos]);
        pos++;
      end
    end
  endtask

  function automatic int total_data();
    int t = 0;
    for (int r = 0; r < TX_REGION_COUNT; r++)
      t += int'(TX_REGIONS[r].size);
    return t;
  endfunction

  // Source and receiver driver.
  initial begin
    forever begin
      @(negedge sys_clk);
      popped = src_valid && src_ready && !reset;
      if (ioctl_wr && !reset) begin
        drv_pulses++;
        if (drv_pulses == bp_at) bp_left = 10;
        if (drv_pulses == starve_at) starve_left = 20;
      end
      @(posedge sys_clk);
      #1;
      if (popped) src_pos++;
      src_data = src_mem[src_pos];
      if (bp_left > 0) begin
        ioctl_wait = 1'b1;
        bp_left--;
      end else begin
        ioctl_wait = rnd_wait &&
                     ($urandom_range(0, 4) == 0);
      end
      if (starve_left > 0) begin
        src_valid = 1'b0;
        starving  = 1'b1;
        starve_left--;
      end else begin
        starving  = 1'b0;
        src_valid = rnd_valid ?
                    ($urandom_range(0, 9) < 7) : 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every pulse.
  always @(negedge sys_clk) begin
    logic [7:0] e;
    int gap;
    bit ok;
    cyc++;
    if (reset) begin
      pulse_n = 0;
    end else begin
      if (!ioctl_downl) pulse_n = 0;
      if (done) done_n++;
      if (src_ready && !src_valid) rdy_bad = 1'b1;
      if (starving && (ioctl_wr || src_ready))
        starve_bad = 1'b1;
      if (!ioctl_wr && ioctl_data != last_data)
        moved = 1'b1;
      if (ioctl_wr) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_byte", {24'h0, ioctl_data},
                   32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq($sformatf("byte#%0d", pulse_n),
                   {24'h0, ioctl_data}, {24'h0, e});
        end
        if (pulse_n > 0) begin
          gap = cyc - last_cyc;
          ok  = gap >= WR_GAP + 1 && !wait_prev &&
                !moved && ioctl_downl &&
                (!strict || gap == WR_GAP + 1);
          check_eq($sformatf("pace#%0d gap=%0d wait=%0b",
                             pulse_n, gap, wait_prev),
                   {31'h0, ok}, 32'd1);
          if (pulse_n == 4) bp_gap = gap;
        end
        moved    = 1'b0;
        last_cyc = cyc;
        pulse_n++;
      end
    end
    last_data = ioctl_data;
    wait_prev = ioctl_wait;
  end

  task automatic run_stream(input logic [7:0] cfg,
                            input bit rv,
                            input bit rw,
                            input int bp,
                            input int stv,
                            input bit ign,
                            input int rst_at,
                            input bit nominal);
    bit ign_done;
    bit seen;
    for (int i = 0; i < 512; i++)
      src_mem[i] = 8'($urandom);
    if (nominal) begin
      src_mem[0] = 8'h11;
      src_mem[1] = 8'h22;
      src_mem[2] = 8'h33;
      src_mem[3] = 8'h44;
    end
    build_exp(cfg);
    rnd_valid  = rv;
    rnd_wait   = rw;
    bp_at      = bp;
    starve_at  = stv;
    strict     = !rv && !rw && bp == 0 && stv == 0;
    src_pos    = 0;
    drv_pulses = 0;
    done_n     = 0;
    starve_bad = 1'b0;
    rdy_bad    = 1'b0;
    bp_gap     = 0;
    src_data   = src_mem[0];
    @(posedge sys_clk);
    #1 start = 1'b1;
    board_cfg = cfg;
    @(posedge sys_clk);
    #1 start = 1'b0;
    board_cfg = 8'($urandom);
    check_eq("open", {29'h0, ioctl_downl, busy, ioctl_wr},
             32'b110);
    @(posedge sys_clk);
    #1;
    check_eq("first_pulse", {23'h0, ioctl_wr, ioctl_data},
             {23'h0, 1'b1, cfg});
    ign_done = 1'b0;
    seen     = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(negedge sys_clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (ign && !ign_done && pulse_n >= 20) begin
        start    = 1'b1;
        ign_done = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
      end
      if (rst_at > 0 && pulse_n >= rst_at) begin
        reset = 1'b1;
        #1;
        check_eq("reset_outputs",
                 {18'h0, src_ready, ioctl_downl, ioctl_wr,
                  ioctl_data, busy, done, 3'b0}, 32'h0);
        exp_q.delete();
        @(negedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b0;
        return;
      end
    end
    check_eq("done_seen", {31'h0, seen}, 32'd1);
    if (!seen) return;
    check_eq("close", {29'h0, ioctl_downl, busy, done},
             32'b011);
    @(negedge sys_clk);
    check_eq("idle", {29'h0, ioctl_downl, busy, done},
             32'b000);
    check_eq("done_count", done_n, 32'd1);
    check_eq("drained", exp_q.size(), 32'd0);
    check_eq("consumed", src_pos, total_data());
    check_eq("ready_gated", {31'h0, rdy_bad}, 32'd0);
    if (stv > 0)
      check_eq("starve_quiet", {31'h0, starve_bad}, 32'd0);
    if (bp > 0)
      check_eq("bp_gap", bp_gap, 32'd12);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    board_cfg  = 8'h00;
    src_valid  = 1'b0;
    src_data   = 8'h00;
    ioctl_wait = 1'b0;
    for (int i = 0; i < 512; i++) src_mem[i] = 8'h00;
    repeat (3) @(negedge sys_clk);
    check_eq("reset_state",
             {18'h0, src_ready, ioctl_downl, ioctl_wr,
              ioctl_data, busy, done, 3'b0}, 32'h0);
    reset = 1'b0;
    @(negedge sys_clk);

    run_stream(8'h5A, 0, 0, 0, 0, 0, 0, 1);
    run_stream(8'($urandom), 0, 0, 4, 0, 0, 0, 0);
    run_stream(8'($urandom), 0, 0, 0, 7, 0, 0, 0);
    run_stream(8'($urandom), 0, 0, 0, 0, 1, 0, 0);
    run_stream(8'($urandom), 0, 0, 0, 0, 0, 117, 0);
    run_stream(8'($urandom), 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      run_stream(8'($urandom), 1, 1, 0, 0, 0, 0, 0);

    repeat (4) @(negedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
